// File: rtl/irq_nios2_qsys_dct_reader.sv
// irq_nios2_qsys_dct_reader
// Consumer end of the Nios II OCI data-capture trace path. Packed capture
// words (ten 3-bit fields plus a field count) are queued in a small FIFO,
// then unpacked LSB-first into a valid/ready symbol stream. An end-of-test
// request drains everything still buffered and then raises a sticky
// completion flag.
// Optional feature macro: DCT_READER_DROP_COUNT_EN adds drop_count, a
// saturating count of every dropped write.
module irq_nios2_qsys_dct_reader #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [29:0]   dct_buffer,
  input  logic [3:0]    dct_count,
  input  logic          dct_wr,
  output logic [2:0]    sym_data,
  output logic          sym_valid,
  input  logic          sym_ready,
  output logic          sym_last,
  input  logic          test_ending,
  output logic          test_has_ended,
  output logic [AW:0]   fill_level,
`ifdef DCT_READER_DROP_COUNT_EN
  output logic [7:0]    drop_count,
`endif
  output logic          overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] ENDED = 2'd3;

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Each FIFO entry is {count, buffer}.
  logic [33:0]  mem_q [DEPTH];
  logic [AW:0]  wrPtr_q, wrPtr_d;
  logic [AW:0]  rdPtr_q, rdPtr_d;
  logic [AW:0]  fillNow;
  logic [AW:0]  fillNext;
  logic [29:0]  shift_q, shift_d;
  logic [3:0]   remaining_q, remaining_d;
  logic         symValid_q, symValid_d;
  logic [1:0]   state_q, state_d;
  logic         overflow_q, overflow_d;

  logic         fifoEmpty;
  logic         fifoFull;
  logic         legalCount;
  logic         drainStarted;
  logic         accept;
  logic         wordDone;
  logic         popWord;
  logic         pushOk;
  logic         dropFull;
  logic [33:0]  headWord;

  assign fillNow      = wrPtr_q - rdPtr_q;
  assign fifoEmpty    = (fillNow == '0);
  assign fifoFull     = (fillNow == FULL_LEVEL);
  assign legalCount   = (dct_count != 4'd0) && (dct_count <= 4'd10);
  assign drainStarted = (state_q == DRAIN) || (state_q == ENDED);
  assign headWord     = mem_q[rdPtr_q[AW-1:0]];

  // A word leaves the FIFO whenever the shift register is empty or its final
  // field is being accepted, so consecutive words stream with no bubble.
  assign accept   = symValid_q & sym_ready;
  assign wordDone = accept & (remaining_q == 4'd1);
  assign popWord  = (state_q != ENDED) & ~fifoEmpty & (~symValid_q | wordDone);

  // A full FIFO still takes a word when the head is leaving in the same cycle.
  assign pushOk   = dct_wr & legalCount & ~drainStarted & (~fifoFull | popWord);
  assign dropFull = dct_wr & legalCount & ~drainStarted & fifoFull & ~popWord;

  assign wrPtr_d  = wrPtr_q + (AW + 1)'(pushOk);
  assign rdPtr_d  = rdPtr_q + (AW + 1)'(popWord);
  assign fillNext = wrPtr_d - rdPtr_d;

  // Unpacking datapath and state transitions; the drain finishes the moment
  // nothing is left in flight or queued after this cycle.
  always_comb begin
    shift_d     = shift_q;
    remaining_d = remaining_q;
    symValid_d  = symValid_q;
    state_d     = state_q;
    overflow_d  = overflow_q | dropFull;

    if (popWord) begin
      shift_d     = headWord[29:0];
      remaining_d = headWord[33:30];
      symValid_d  = 1'b1;
    end else if (wordDone) begin
      shift_d     = shift_q >> 3;
      remaining_d = 4'd0;
      symValid_d  = 1'b0;
    end else if (accept) begin
      shift_d     = shift_q >> 3;
      remaining_d = remaining_q - 4'd1;
    end

    case (state_q)
      IDLE, EMIT: begin
        if (test_ending) begin
          state_d = (!symValid_d && fillNext == '0) ? ENDED : DRAIN;
        end else begin
          state_d = symValid_d ? EMIT : IDLE;
        end
      end
      DRAIN: begin
        if (!symValid_d && fillNext == '0) begin
          state_d = ENDED;
        end
      end
      default: begin
        symValid_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; stale contents are harmless because the pointers define it.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q[AW-1:0]] <= {dct_count, dct_buffer};
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      shift_q     <= '0;
      remaining_q <= '0;
      symValid_q  <= 1'b0;
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      symValid_q  <= symValid_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef DCT_READER_DROP_COUNT_EN
  logic [7:0] dropCount_q, dropCount_d;
  logic       anyDrop;

  assign anyDrop = dct_wr & (~legalCount | drainStarted | (fifoFull & ~popWord));

  // Saturating tally of every write that did not enter the FIFO.
  always_comb begin
    dropCount_d = dropCount_q;
    if (anyDrop && dropCount_q != 8'hFF) begin
      dropCount_d = dropCount_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dropCount_q <= '0;
    end else begin
      dropCount_q <= dropCount_d;
    end
  end

  assign drop_count = dropCount_q;
`endif

  assign sym_data       = shift_q[2:0];
  assign sym_valid      = symValid_q;
  assign sym_last       = symValid_q & (remaining_q == 4'd1);
  assign test_has_ended = (state_q == ENDED);
  assign fill_level     = fillNow;
  assign overflow       = overflow_q;

endmodule
